prewitt_stream_ctrl: RTL

//   Streaming sequencer for the Prewitt edge datapath. Accepts one frame of raster-order 8-bit pixels over a

---
 rtl/prewitt_stream_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/prewitt_stream_ctrl.sv
// Streaming Prewitt |Gx|+|Gy| sequencer; output register loads on the edge that accepts input index o+COLS+1.
// Backpressure: out_ready low holds the output and drops in_ready; optional PREWITT_THRESH_EN adds a threshold port.
module prewitt_stream_ctrl #(
    parameter int ROWS = 242,
    parameter int COLS = 247,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pixel,
    output logic          busy,
    output logic          done
`ifdef PREWITT_THRESH_EN
    ,
    input  logic [DW-1:0] thresh
`endif
);

    localparam int TOTAL = ROWS * COLS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int CLW   = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int SW    = DW + 3;

    localparam logic [CW-1:0]  LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0]  TOTAL_C  = CW'(TOTAL);
    localparam logic [CW-1:0]  LAG      = CW'(COLS + 1);
    localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
    localparam logic [DW-1:0]  MAXV     = {DW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;
    state_t state;

    logic [CW-1:0]  in_cnt;
    logic [CLW-1:0] in_col;
    logic [CW-1:0]  ld_cnt;
    logic [RW-1:0]  ld_row;
    logic [CLW-1:0] ld_col;
    logic [CW-1:0]  ack_cnt;

    logic [DW-1:0] lb0 [COLS];
    logic [DW-1:0] lb1 [COLS];
    logic [DW-1:0] w0_t, w0_m, w0_b;
    logic [DW-1:0] w1_t, w1_m, w1_b;

    logic room, in_fire, out_fire, load, border;
    logic [DW-1:0] n_t, n_m, n_b;
    logic signed [SW-1:0] sx, sy;
    logic [SW-1:0] ax, ay;
    logic [SW:0]   mag;
    logic [DW-1:0] sat, edge_val;

    function automatic logic signed [SW-1:0] ext(input logic [DW-1:0] v);
        return $signed({3'b000, v});
    endfunction

    assign room     = !out_valid || out_ready;
    assign in_ready = (state == S_RUN) && room;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign load     = (in_fire && (in_cnt >= LAG)) ||
                      ((state == S_DRAIN) && room && (ld_cnt != TOTAL_C));
    assign border   = (ld_row == '0) || (ld_row == ROW_LAST) ||
                      (ld_col == '0) || (ld_col == COL_LAST);

    // The incoming pixel completes the window's right column; the window is
    // centred one row up and one column left of it.
    assign n_t = lb1[in_col];
    assign n_m = lb0[in_col];
    assign n_b = in_pixel;

    always_comb begin
        sx  = (ext(w0_t) + ext(w1_t) + ext(n_t)) - (ext(w0_b) + ext(w1_b) + ext(n_b));
        sy  = (ext(w0_t) + ext(w0_m) + ext(w0_b)) - (ext(n_t) + ext(n_m) + ext(n_b));
        ax  = sx[SW-1] ? -sx : sx;
        ay  = sy[SW-1] ? -sy : sy;
        mag = {1'b0, ax} + {1'b0, ay};
        sat = (mag > {{(SW+1-DW){1'b0}}, MAXV}) ? MAXV : mag[DW-1:0];
`ifdef PREWITT_THRESH_EN
        edge_val = (sat >= thresh) ? MAXV : '0;
`else
        edge_val = sat;
`endif
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            lb0[in_col] <= in_pixel;
            lb1[in_col] <= lb0[in_col];
            w0_t <= w1_t;
            w0_m <= w1_m;
            w0_b <= w1_b;
            w1_t <= n_t;
            w1_m <= n_m;
            w1_b <= n_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_cnt    <= '0;
            in_col    <= '0;
            ld_cnt    <= '0;
            ld_row    <= '0;
            ld_col    <= '0;
            ack_cnt   <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        in_cnt  <= '0;
                        in_col  <= '0;
                        ld_cnt  <= '0;
                        ld_row  <= '0;
                        ld_col  <= '0;
                        ack_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (in_fire && (in_cnt == LAST_IDX))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_fire && (ack_cnt == LAST_IDX)) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (in_fire) begin
                in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
                in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
            end

            // A load during an output handshake keeps out_valid high.
            if (load) begin
                out_valid <= 1'b1;
                out_pixel <= border ? '0 : edge_val;
                ld_cnt    <= ld_cnt + 1'b1;
                if (ld_col == COL_LAST) begin
                    ld_col <= '0;
                    ld_row <= (ld_row == ROW_LAST) ? '0 : ld_row + 1'b1;
                end else begin
                    ld_col <= ld_col + 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (out_fire)
                ack_cnt <= (ack_cnt == LAST_IDX) ? '0 : ack_cnt + 1'b1;
        end
    end

endmodule
